// File: rtl/mdu_issue_ctrl.sv
// ============================================================================
// mdu_issue_ctrl
// ----------------------------------------------------------------------------
// Issue and sequencing controller for the E-stage multiply/divide unit.
//
// What it does:
//   - Decodes the MDU op code in E.
//   - Launches mult/multu/div/divu with a single-cycle start pulse.
//   - Counts the operation latency down while holding busy.
//   - Fires the HI/LO commit strobe in the last busy cycle.
//   - Generates the D-stage stall.
//   - Gates every MDU side effect with the exception request Req, so the
//     MDU datapath itself holds no timing state.
//
// Op code map (shared by op_D and op_E):
//   0 none, 1 mult, 2 multu, 3 div, 4 divu,
//   5 mfhi, 6 mflo, 7 mthi, 8 mtlo, 9..15 none.
//
// Ports:
//   clk          in   system clock, rising edge
//   reset        in   synchronous reset, active low
//   op_D[3:0]    in   MDU op code of the instruction in D
//   op_E[3:0]    in   MDU op code of the instruction in E
//   Req          in   exception/interrupt flush of the E instruction
//   start        out  combinational; launch mult/multu/div/divu
//   busy         out  registered; an operation is in flight
//   hilo_commit  out  state decode; load HI/LO from the MDU result
//   mt_we_hi     out  combinational; mthi writes HI
//   mt_we_lo     out  combinational; mtlo writes LO
//   inflight_op  out  op code of the in-flight operation, 0 when idle
//   stall_D      out  combinational; freeze F/D and bubble E
//
// Optional feature: define MDU_CANCEL_EN to let Req abort an in-flight
// operation. The abort suppresses the commit, so HI/LO keep their old
// values. When MDU_CANCEL_EN is undefined, an operation that has started
// always runs to completion.
// ============================================================================
module mdu_issue_ctrl #(
    parameter int MULT_LAT = 5,   // busy cycles for mult/multu (1..15)
    parameter int DIV_LAT  = 10,  // busy cycles for div/divu (1..15)
    parameter int CNT_W    = 4    // countdown width, holds max latency
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] op_D,
    input  logic [3:0] op_E,
    input  logic       Req,
    output logic       start,
    output logic       busy,
    output logic       hilo_commit,
    output logic       mt_we_hi,
    output logic       mt_we_lo,
    output logic [3:0] inflight_op,
    output logic       stall_D
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_LAST = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_LAT);
    localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_LAT);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_TWO  = CNT_W'(2);

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             busy_reg, busy_next;
    logic [3:0]       inflight_reg, inflight_next;

    // One-hot decode of the MDU-class ops.
    // op_e_md[1..4] : mult, multu, div, divu in E.
    // op_d_hit[1..8]: any MDU-related op in D.
    logic [4:1] op_e_md;
    logic [8:1] op_d_hit;

    genvar gi;
    generate
        for (gi = 1; gi <= 4; gi++) begin : g_op_e
            assign op_e_md[gi] = (op_E == 4'(gi));
        end
        for (gi = 1; gi <= 8; gi++) begin : g_op_d
            assign op_d_hit[gi] = (op_D == 4'(gi));
        end
    endgenerate

    logic             e_is_muldiv;
    logic             e_is_div;
    logic [CNT_W-1:0] lat_sel;
    logic             abort;

    assign e_is_muldiv = |op_e_md;
    assign e_is_div    = op_e_md[3] | op_e_md[4];
    assign lat_sel     = e_is_div ? DIV_CNT : MULT_CNT;

`ifdef MDU_CANCEL_EN
    assign abort = busy_reg & Req;
`else
    assign abort = 1'b0;
`endif

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg    <= ST_IDLE;
            cnt_reg      <= '0;
            busy_reg     <= 1'b0;
            inflight_reg <= '0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            busy_reg     <= busy_next;
            inflight_reg <= inflight_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        busy_next     = busy_reg;
        inflight_next = inflight_reg;

        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    cnt_next      = lat_sel;
                    busy_next     = 1'b1;
                    inflight_next = op_E;
                    // A latency of one goes straight to the commit cycle.
                    state_next    = (lat_sel == CNT_ONE) ? ST_LAST : ST_RUN;
                end
            end
            ST_RUN: begin
                cnt_next = cnt_reg - CNT_ONE;
                // The count moves from 2 to 1 here, so the next cycle is
                // the commit cycle.
                if (cnt_reg == CNT_TWO) begin
                    state_next = ST_LAST;
                end
            end
            ST_LAST: begin
                cnt_next      = '0;
                busy_next     = 1'b0;
                inflight_next = '0;
                state_next    = ST_IDLE;
            end
            default: begin
                cnt_next      = '0;
                busy_next     = 1'b0;
                inflight_next = '0;
                state_next    = ST_IDLE;
            end
        endcase

        // An abort overrides the countdown in both RUN and LAST.
        if (abort) begin
            cnt_next      = '0;
            busy_next     = 1'b0;
            inflight_next = '0;
            state_next    = ST_IDLE;
        end
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    always_comb begin
        start       = (state_reg == ST_IDLE) && !Req && e_is_muldiv;
        hilo_commit = (state_reg == ST_LAST) && !abort;
        mt_we_hi    = (op_E == 4'd7) && !Req && !busy_reg;
        mt_we_lo    = (op_E == 4'd8) && !Req && !busy_reg;
        // Only MDU-related instructions in D wait on the unit.
        stall_D     = (|op_d_hit) && (start || busy_reg);
    end

    assign busy        = busy_reg;
    assign inflight_op = inflight_reg;

endmodule

// File: doc/mdu_issue_ctrl.md
Name: mdu_issue_ctrl

Overview:
- Issue/sequencing controller for the E-stage multiply/divide unit (MDU) of the pipelined CPU.
- Decodes the MDU op code in E, generates the start pulse, and runs the latency countdown that holds busy.
- Fires the HI/LO commit strobe at the end of the operation and produces the D-stage stall.
- Owns all exception (Req) gating of MDU side effects, so the MDU datapath itself carries no timing state.

Parameters:
- MULT_LAT, 5, busy cycles for mult/multu (1..15).
- DIV_LAT, 10, busy cycles for div/divu (1..15).
- CNT_W, 4, countdown width; must hold max(MULT_LAT, DIV_LAT).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- op_D  in  4  MDU op code of the instruction in D.
- op_E  in  4  MDU op code of the instruction in E.
- Req  in  1  exception/interrupt request; the E instruction is being flushed this cycle.
- start  out  1  combinational; launch mult/multu/div/divu this cycle.
- busy  out  1  registered; an operation is in flight.
- hilo_commit  out  1  registered-state decode; load HI/LO from the MDU result this cycle.
- mt_we_hi  out  1  combinational; mthi writes HI this cycle.
- mt_we_lo  out  1  combinational; mtlo writes LO this cycle.
- inflight_op  out  4  op code of the in-flight operation; 0 when idle.
- stall_D  out  1  combinational; freeze F/D and bubble E.

Behaviour:
- Op code map: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo, 9..15 none. The same map applies to op_D and op_E.
- Reset (reset==0 at a clk edge):
  - state=IDLE, cnt=0, inflight_op=0.
  - busy=0 and hilo_commit=0.
  - Combinational outputs follow their equations.
  - Reset mid-operation abandons the operation with no commit.
- States:
  - IDLE: cnt==0.
  - RUN: cnt>1.
  - LAST: cnt==1.
- start = (state==IDLE) && !Req && op_E in {1,2,3,4}.
- IDLE with start:
  - cnt <= MULT_LAT for ops 1/2, DIV_LAT for ops 3/4.
  - inflight_op <= op_E; busy <= 1.
  - If the loaded latency is 1, the next state is LAST.
- RUN: cnt <= cnt-1 each cycle; Req is ignored (the operation completes).
- LAST:
  - hilo_commit=1 for exactly this cycle.
  - At the edge: cnt <= 0, busy <= 0, inflight_op <= 0.
- Timing: start in cycle t gives busy=1 in cycles t+1..t+LAT and hilo_commit=1 in cycle t+LAT. busy=0 from t+LAT+1.
- Back-to-back MDU ops:
  - A new start is possible at the earliest in cycle t+LAT+1.
  - There is no overlap, because stall_D holds the next op out of E.
- mthi/mtlo:
  - mt_we_hi = (op_E==7) && !Req && !busy.
  - mt_we_lo = (op_E==8) && !Req && !busy.
  - Single cycle; no state change.
- stall_D = (op_D in 1..8) && (start || busy). Non-MDU instructions never stall on this block.
- Req:
  - Suppresses start, mt_we_hi and mt_we_lo in the same cycle.
  - Never suppresses a hilo_commit already due (see the optional feature).
- An mfhi/mflo in E while busy cannot occur by construction (stall_D). The block does not check for it.
- Op codes 9..15 behave as 0.

Optional Feature:
- Macro MDU_CANCEL_EN.
- Defined: Req==1 while busy (RUN or LAST) aborts the operation.
  - Next state IDLE, cnt=0, busy=0, inflight_op=0.
  - hilo_commit is forced to 0 in that cycle, so HI/LO keep their old values.
- Undefined: Req has no effect on an in-flight operation; the countdown and commit proceed as specified.

Test Plan:
- Reset: hold reset=0 with op_E=1 → busy=0, hilo_commit=0, inflight_op=0 and no start after release until op_E is presented with reset=1.
- mult: op_E=1 at cycle 10, Req=0 → start=1 at 10; busy=1 at 11..15; hilo_commit=1 only at 15; busy=0 at 16.
- div with stall: op_E=3 at 20, op_D=6 during 20..30 → busy 21..30, hilo_commit at 30, stall_D=1 at 20..30, stall_D=0 at 31.
- Req gating: op_E=2 with Req=1 → start=0, busy stays 0. op_E=7 with Req=1 → mt_we_hi=0. op_E=8 with Req=0 → mt_we_lo=1 for one cycle.
- Req mid-op: start divu at 40, Req=1 at 44.
  - MDU_CANCEL_EN undefined: busy 41..50, hilo_commit at 50.
  - MDU_CANCEL_EN defined: busy=0 from 45, no hilo_commit.
- Reset mid-op: start mult at 60, reset=0 at 62 → busy=0 at 63, no hilo_commit in 63..66.
